// File: rtl/mash111_acc_chain.sv
// mash111_acc_chain
// Three cascaded P_WIDTH-bit accumulators forming the integrating front end of
// a MASH 1-1-1 delta-sigma modulator. Each stage emits a registered carry
// (o_quantize1..3) for the downstream noise-cancellation network. A one-word
// shadow register with a valid/ready handshake lets the fractional word be
// retuned between samples without tearing a sample.
//
// Build option: define MASH_DITHER_EN to add a 15-bit LFSR (x^15+x^14+1,
// seed 15'h0001) whose bit 0 becomes the stage-1 carry-in. When it is left
// undefined, no LFSR is built and the carry-in is tied to zero.

module mash111_acc_chain #(
    parameter int P_WIDTH = 24
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [P_WIDTH-1:0] i_frac,
    input  logic               i_frac_vld,
    output logic               o_frac_rdy,
    output logic               o_quantize1,
    output logic               o_quantize2,
    output logic               o_quantize3
);

    // P_WIDTH+1 bit sum of two words plus a carry-in; the MSB is the stage carry.
    function automatic logic [P_WIDTH:0] add_w(
        input logic [P_WIDTH-1:0] a,
        input logic [P_WIDTH-1:0] b,
        input logic               c
    );
        return {1'b0, a} + {1'b0, b} + {{P_WIDTH{1'b0}}, c};
    endfunction

    logic [P_WIDTH-1:0] acc1_r;
    logic [P_WIDTH-1:0] acc2_r;
    logic [P_WIDTH-1:0] acc3_r;
    logic [P_WIDTH-1:0] frac_act_r;
    logic [P_WIDTH-1:0] frac_shd_r;
    logic               shd_full_r;
    logic               q1_r;
    logic               q2_r;
    logic               q3_r;

    logic               step_s;
    logic               xfer_s;
    logic               apply_s;
    logic               cin_s;
    logic [P_WIDTH:0]   s1_s;
    logic [P_WIDTH:0]   s2_s;
    logic [P_WIDTH:0]   s3_s;

    // Qualify the sample strobe and the handshake events.
    always_comb begin
        step_s  = i_en & ~i_clr;
        xfer_s  = i_frac_vld & ~shd_full_r;
        apply_s = step_s & shd_full_r;
    end

`ifdef MASH_DITHER_EN
    localparam logic [14:0] LFSR_SEED = 15'h0001;

    logic [14:0] lfsr_r;

    // One Fibonacci shift of the x^15+x^14+1 dither generator.
    function automatic logic [14:0] lfsr_next(input logic [14:0] cur);
        return {cur[13:0], cur[14] ^ cur[13]};
    endfunction

    // Dither LFSR: advances on every sample strobe, clear or not.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (i_en) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Carry-in is the LFSR LSB as it stands before this edge's shift.
    always_comb begin
        cin_s = lfsr_r[0];
    end
`else
    // No dither: stage-1 carry-in is constant zero.
    always_comb begin
        cin_s = 1'b0;
    end
`endif

    // Cascaded sums; each stage integrates the previous stage's wrapped result.
    always_comb begin
        s1_s = add_w(acc1_r, frac_act_r, cin_s);
        s2_s = add_w(acc2_r, s1_s[P_WIDTH-1:0], 1'b0);
        s3_s = add_w(acc3_r, s2_s[P_WIDTH-1:0], 1'b0);
    end

    // Accumulators and carries: clear wins, otherwise advance on i_en, else hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc1_r <= {P_WIDTH{1'b0}};
            acc2_r <= {P_WIDTH{1'b0}};
            acc3_r <= {P_WIDTH{1'b0}};
            q1_r   <= 1'b0;
            q2_r   <= 1'b0;
            q3_r   <= 1'b0;
        end else if (i_clr) begin
            acc1_r <= {P_WIDTH{1'b0}};
            acc2_r <= {P_WIDTH{1'b0}};
            acc3_r <= {P_WIDTH{1'b0}};
            q1_r   <= 1'b0;
            q2_r   <= 1'b0;
            q3_r   <= 1'b0;
        end else if (i_en) begin
            acc1_r <= s1_s[P_WIDTH-1:0];
            acc2_r <= s2_s[P_WIDTH-1:0];
            acc3_r <= s3_s[P_WIDTH-1:0];
            q1_r   <= s1_s[P_WIDTH];
            q2_r   <= s2_s[P_WIDTH];
            q3_r   <= s3_s[P_WIDTH];
        end else begin
            acc1_r <= acc1_r;
            acc2_r <= acc2_r;
            acc3_r <= acc3_r;
            q1_r   <= q1_r;
            q2_r   <= q2_r;
            q3_r   <= q3_r;
        end
    end

    // Shadow handshake: a transfer needs an empty shadow and an apply needs a
    // full one, so the two can never coincide. The apply edge still sums with
    // the old active word because s1_s reads frac_act_r before it updates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frac_act_r <= {P_WIDTH{1'b0}};
            frac_shd_r <= {P_WIDTH{1'b0}};
            shd_full_r <= 1'b0;
        end else if (xfer_s) begin
            frac_act_r <= frac_act_r;
            frac_shd_r <= i_frac;
            shd_full_r <= 1'b1;
        end else if (apply_s) begin
            frac_act_r <= frac_shd_r;
            frac_shd_r <= frac_shd_r;
            shd_full_r <= 1'b0;
        end else begin
            frac_act_r <= frac_act_r;
            frac_shd_r <= frac_shd_r;
            shd_full_r <= shd_full_r;
        end
    end

    assign o_frac_rdy  = ~shd_full_r;
    assign o_quantize1 = q1_r;
    assign o_quantize2 = q2_r;
    assign o_quantize3 = q3_r;

endmodule

// File: doc/mash111_acc_chain.md
# mash111_acc_chain

Three-stage cascaded accumulator front end of the MASH 1-1-1 delta-sigma modulator. It integrates a P_WIDTH-bit fractional word and emits the three single-bit stage carries that the noise-cancellation network consumes as its quantize1/quantize2/quantize3 inputs. A valid/ready shadow register lets the frequency-control side retune the fractional word without tearing a sample. The block sits between the frequency-control register interface and the noise-cancellation network, in the same clock domain.

## Interface
- P_WIDTH, 24, accumulator and fractional-word width in bits; legal range 4..32
- i_clk  in  1  modulator clock
- i_rst_n  in  1  reset; one clock, asynchronous, active-low
- i_en  in  1  sample strobe; accumulators advance only on edges where it is 1
- i_clr  in  1  synchronous clear of accumulators and carries; overrides i_en
- i_frac  in  P_WIDTH  new fractional word
- i_frac_vld  in  1  i_frac valid
- o_frac_rdy  out  1  shadow register empty, word can be accepted
- o_quantize1  out  1  stage-1 carry, registered
- o_quantize2  out  1  stage-2 carry, registered
- o_quantize3  out  1  stage-3 carry, registered

## Operation
- State registers: acc1, acc2, acc3 (P_WIDTH each), frac_act (active word), frac_shd (shadow word), shd_full.
- Handshake: a transfer occurs on an edge where i_frac_vld & o_frac_rdy. On transfer, frac_shd <= i_frac and shd_full <= 1. o_frac_rdy = ~shd_full, driven from the register.
- Apply: on an edge where i_en=1, i_clr=0 and shd_full=1, frac_act <= frac_shd and shd_full <= 0. The accumulation on that same edge still uses the old frac_act.
- Accumulate, on edges where i_en=1 and i_clr=0, with widths P_WIDTH+1:
  - s1 = acc1 + frac_act + cin
  - s2 = acc2 + s1[P_WIDTH-1:0]
  - s3 = acc3 + s2[P_WIDTH-1:0]
  - accN <= sN[P_WIDTH-1:0]; o_quantizeN <= sN[P_WIDTH]
  - cin is 0 unless dither is enabled (see Configuration).
- Hold: on edges where i_en=0, all accumulators and carries hold their values. The handshake still operates.
- Clear: i_clr=1 sets acc1..3 and all carries to 0. It does not touch frac_act, frac_shd, shd_full or the LFSR.
- All three carries come from one sample. Stage alignment and differencing belong to the downstream network.

## Timing
- Reset values: all accumulators 0, frac_act 0, frac_shd 0, shd_full 0 (so o_frac_rdy=1), o_quantize1..3 = 0, LFSR = 15'h0001.
- Carry latency: carries are valid one edge after the i_en edge that computed them, and are held until the next i_en edge.
- Retune latency: a word accepted at edge k becomes frac_act at the first i_en edge strictly after k. Its first effect on the carries appears at the i_en edge after that.
- Transfer and i_en on the same edge: the shadow loads and frac_act is unchanged. The shadow is applied at the next i_en edge.
- i_frac_vld held while o_frac_rdy=0: no transfer. The shadow keeps its first word, and the input is not required to be stable across this.
- Wrap-around: accumulators are modulo 2^P_WIDTH; overflow produces only the carry.
- frac_act=0 with cin=0: all carries stay 0.
- Asynchronous reset mid-operation: every register returns to its reset value immediately. The block accepts a new word on the first edge after release.

## Configuration
- MASH_DITHER_EN defined:
  - A 15-bit Fibonacci LFSR (x^15+x^14+1, seed 15'h0001) advances on every i_en edge, including edges where i_clr=1.
  - cin = LFSR bit 0, as it stands before the shift.
  - This breaks limit cycles for rational fractional words.
- MASH_DITHER_EN undefined: no LFSR is built and cin = 0.

## Test plan
- P_WIDTH=8, dither off, frac 64 loaded then four i_en pulses after apply -> (q1,q2,q3) over the four samples = (0,0,0),(0,0,1),(0,1,0),(1,0,1); acc1 back to 0.
- Handshake: vld=1 with word 0x10, then vld=1 with 0x20 while rdy=0, no i_en -> shadow=0x10, rdy stays 0; one i_en -> frac_act=0x10, rdy=1 next cycle.
- Transfer on the same edge as i_en -> frac_act unchanged that edge, applied at the next i_en.
- i_en=0 for 10 cycles mid-run -> carries and accumulators frozen; i_clr=1 -> carries and accumulators 0, frac_act retained.
- P_WIDTH=24, frac 0x400000, 4096 samples -> q1 count = 1024, and the mean of the downstream-equivalent sum q1+Δq2+Δ²q3 = 0.25 exactly.
- Assert i_rst_n low mid-run with shadow full -> all outputs at reset values; with MASH_DITHER_EN, frac 0 yields a nonzero q1 density, and without it q1 stays 0.
